// File: rtl/axis_pattern_source.sv
// AXI4-Stream master emitting deterministic packets (count / constant / LFSR / walking one).
// Optional stall counter output enabled by defining AXIS_PATTERN_SOURCE_STALL_CNT_EN.
module axis_pattern_source #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                CLK_dma,
    input  logic                peripheral_aresetn,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [1:0]          i_mode,
    input  logic [DATA_W-1:0]   i_seed,
    input  logic [LEN_W-1:0]    i_pkt_len,
    input  logic [LEN_W-1:0]    i_pkt_count,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                o_busy,
    output logic                o_done,
`ifdef AXIS_PATTERN_SOURCE_STALL_CNT_EN
    output logic [31:0]         o_stall_cnt,
`endif
    output logic [31:0]         o_beat_cnt
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
    localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h8020_0003);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [1:0]         mode_q, mode_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [LEN_W-1:0]   beat_idx_q, beat_idx_d;
    logic [LEN_W-1:0]   pkt_idx_q, pkt_idx_d;
    logic               abort_q, abort_d;
    logic [31:0]        beat_cnt_q, beat_cnt_d;

    logic start_pulse;
    logic start_acc;
    logic xfer;
    logic last_beat;

    function automatic logic [DATA_W-1:0] first_pattern(input logic [1:0] mode,
                                                        input logic [DATA_W-1:0] seed);
        logic [DATA_W-1:0] p;
        case (mode)
            2'd2:    p = (seed == '0) ? ONE : seed;
            2'd3:    p = ONE << seed[SH_W-1:0];
            default: p = seed;
        endcase
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] next_pattern(input logic [1:0] mode,
                                                       input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] n;
        case (mode)
            2'd0:    n = d + ONE;
            2'd2:    n = (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
            2'd3:    n = {d[DATA_W-2:0], d[DATA_W-1]};
            default: n = d;
        endcase
        return n;
    endfunction

    assign start_pulse = i_start & ~start_q;
    assign start_acc   = start_pulse & (state_q != SEND);
    assign xfer        = (state_q == SEND) & m_axis_tready;
    assign last_beat   = (beat_idx_q == len_q - LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        count_d    = count_q;
        data_d     = data_q;
        beat_idx_d = beat_idx_q;
        pkt_idx_d  = pkt_idx_q;
        abort_d    = abort_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    mode_d     = i_mode;
                    len_d      = i_pkt_len;
                    count_d    = i_pkt_count;
                    data_d     = first_pattern(i_mode, i_seed);
                    beat_idx_d = '0;
                    pkt_idx_d  = '0;
                    abort_d    = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = (i_pkt_len == '0 || i_pkt_count == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (i_abort) abort_d = 1'b1;
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    data_d     = next_pattern(mode_q, data_q);
                    if (last_beat) begin
                        // Abort is only honoured here, so a packet is never truncated.
                        beat_idx_d = '0;
                        pkt_idx_d  = pkt_idx_q + LEN_W'(1);
                        if (pkt_idx_q == count_q - LEN_W'(1) || abort_q || i_abort) begin
                            state_d = DONE;
                            abort_d = 1'b0;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_dma or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            mode_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            data_q     <= '0;
            beat_idx_q <= '0;
            pkt_idx_q  <= '0;
            abort_q    <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= i_start;
            mode_q     <= mode_d;
            len_q      <= len_d;
            count_q    <= count_d;
            data_q     <= data_d;
            beat_idx_q <= beat_idx_d;
            pkt_idx_q  <= pkt_idx_d;
            abort_q    <= abort_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef AXIS_PATTERN_SOURCE_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc)
            stall_d = '0;
        else if (m_axis_tvalid && !m_axis_tready && stall_q != 32'hFFFF_FFFF)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge CLK_dma or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) stall_q <= '0;
        else                     stall_q <= stall_d;
    end

    assign o_stall_cnt = stall_q;
`endif

    assign m_axis_tvalid = (state_q == SEND);
    assign m_axis_tlast  = m_axis_tvalid & last_beat;
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = '1;
    assign o_busy        = (state_q == SEND);
    assign o_done        = (state_q == DONE);
    assign o_beat_cnt    = beat_cnt_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Scoreboard bench for axis_pattern_source: a reference model queues expected beats, a monitor pops them.
module tb_axis_pattern_source;

    logic        clk = 1'b0;
    logic        rstN;
    logic        iStart, iAbort;
    logic [1:0]  iMode;
    logic [31:0] iSeed;
    logic [15:0] iPktLen, iPktCount;
    logic [31:0] tData;
    logic [3:0]  tKeep;
    logic        tLast, tValid;
    logic        tReady = 1'b1;
    logic        busy, done;
    logic [31:0] beatCnt;
`ifdef AXIS_PATTERN_SOURCE_STALL_CNT_EN
    logic [31:0] stallCnt;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sbQ[$];
    int    assertCount = 0;
    int    failCount   = 0;
    int    stallSeen   = 0;
    int    readyMode   = 0;
    logic        prevStall = 1'b0;
    logic [31:0] prevData;
    logic        prevLast;

    axis_pattern_source #(.DATA_W(32), .LEN_W(16)) dut (
        .CLK_dma            (clk),
        .peripheral_aresetn (rstN),
        .i_start            (iStart),
        .i_abort            (iAbort),
        .i_mode             (iMode),
        .i_seed             (iSeed),
        .i_pkt_len          (iPktLen),
        .i_pkt_count        (iPktCount),
        .m_axis_tdata       (tData),
        .m_axis_tkeep       (tKeep),
        .m_axis_tlast       (tLast),
        .m_axis_tvalid      (tValid),
        .m_axis_tready      (tReady),
        .o_busy             (busy),
        .o_done             (done),
`ifdef AXIS_PATTERN_SOURCE_STALL_CNT_EN
        .o_stall_cnt        (stallCnt),
`endif
        .o_beat_cnt         (beatCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] refFirst(input int mode, input logic [31:0] seed);
        logic [4:0] sh;
        sh = seed[4:0];
        if (mode == 2) return (seed == 32'd0) ? 32'd1 : seed;
        if (mode == 3) return 32'd1 << sh;
        return seed;
    endfunction

    function automatic logic [31:0] refStep(input int mode, input logic [31:0] d);
        case (mode)
            0:       return d + 32'd1;
            1:       return d;
            2:       return (d >> 1) ^ (d[0] ? 32'h8020_0003 : 32'h0);
            default: return (d << 1) | (d >> 31);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Ready driver: always high, toggling every cycle, or random, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       tReady = 1'b1;
                1:       tReady = ~tReady;
                default: tReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples on the falling edge, pops one expected beat per handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (!rstN) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("hold_valid", {31'd0, tValid}, 32'd1);
                checkOutput("hold_data", tData, prevData);
                checkOutput("hold_last", {31'd0, tLast}, {31'd0, prevLast});
            end
            if (tValid && tReady) begin
                if (sbQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_beat: got data 0x%08h, expected no beat at %0t", tData, $time);
                end else begin
                    beat_t exp;
                    exp = sbQ.pop_front();
                    checkOutput("beat_data", tData, exp.data);
                    checkOutput("beat_last", {31'd0, tLast}, {31'd0, exp.last});
                end
            end
            if (tValid && !tReady) stallSeen++;
            prevStall = tValid && !tReady;
            prevData  = tData;
            prevLast  = tLast;
        end
    end

    // Queues the expected beats of the first expPkts packets, then pulses start for one cycle.
    task automatic applyStimulus(input int mode, input logic [31:0] seed, input int len,
                                 input int count, input int expPkts);
        logic [31:0] d;
        d = refFirst(mode, seed);
        for (int p = 0; p < expPkts; p++) begin
            for (int b = 0; b < len; b++) begin
                sbQ.push_back('{data: d, last: (b == len - 1)});
                d = refStep(mode, d);
            end
        end
        @(posedge clk);
        #1;
        stallSeen = 0;
        iMode     = 2'(mode);
        iSeed     = seed;
        iPktLen   = 16'(len);
        iPktCount = 16'(count);
        iStart    = 1'b1;
        @(posedge clk);
        #1;
        iStart    = 1'b0;
    endtask

    task automatic waitDone(input int bound, input int expBeats);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL done_timeout: got done=0 after %0d cycles, expected done=1", bound);
        end
        checkOutput("done_busy", {31'd0, busy}, 32'd0);
        checkOutput("done_valid", {31'd0, tValid}, 32'd0);
        checkOutput("beat_cnt", beatCnt, 32'(expBeats));
        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
`ifdef AXIS_PATTERN_SOURCE_STALL_CNT_EN
        checkOutput("stall_cnt", stallCnt, 32'(stallSeen));
`endif
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_tvalid"}, {31'd0, tValid}, 32'd0);
        checkOutput({tag, "_tlast"}, {31'd0, tLast}, 32'd0);
        checkOutput({tag, "_tdata"}, tData, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_beatcnt"}, beatCnt, 32'd0);
`ifdef AXIS_PATTERN_SOURCE_STALL_CNT_EN
        checkOutput({tag, "_stallcnt"}, stallCnt, 32'd0);
`endif
    endtask

    initial begin
        rstN = 1'b0; iStart = 1'b0; iAbort = 1'b0; iMode = 2'd0;
        iSeed = 32'd0; iPktLen = 16'd0; iPktCount = 16'd0;
        repeat (3) @(posedge clk);
        #2;
        checkResetState("reset");
        checkOutput("tkeep", {28'd0, tKeep}, 32'hF);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        $display("[TB] mode 0 incrementing, two packets of four");
        readyMode = 0;
        applyStimulus(0, 32'h100, 4, 2, 2);
        repeat (8) @(negedge clk);
        checkOutput("done_not_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        checkOutput("done_one_after_last", {31'd0, done}, 32'd1);
        waitDone(4, 8);

        $display("[TB] mode 2 LFSR with seed 0, ready toggling");
        readyMode = 1;
        applyStimulus(2, 32'd0, 3, 1, 1);
        waitDone(50, 3);

        $display("[TB] mode 3 walking one from bit 31");
        readyMode = 0;
        applyStimulus(3, 32'd31, 2, 1, 1);
        waitDone(20, 2);

        $display("[TB] zero length packets");
        applyStimulus(0, 32'h55, 0, 5, 0);
        @(negedge clk);
        checkOutput("len0_valid", {31'd0, tValid}, 32'd0);
        checkOutput("len0_done", {31'd0, done}, 32'd1);
        checkOutput("len0_busy", {31'd0, busy}, 32'd0);
        checkOutput("len0_beatcnt", beatCnt, 32'd0);
        @(negedge clk);
        checkOutput("len0_valid2", {31'd0, tValid}, 32'd0);

        $display("[TB] abort during first packet");
        applyStimulus(1, 32'hA5A5_A5A5, 8, 4, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        iAbort = 1'b1;
        @(posedge clk);
        #1;
        iAbort = 1'b0;
        waitDone(100, 8);
        repeat (3) @(negedge clk);
        checkOutput("abort_stays_idle", {31'd0, tValid}, 32'd0);

        $display("[TB] second start while busy is ignored");
        readyMode = 2;
        applyStimulus(0, 32'h1000, 4, 3, 3);
        repeat (3) @(posedge clk);
        #1;
        iStart = 1'b1;
        iSeed  = 32'hDEAD_0000;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        waitDone(300, 12);

        $display("[TB] reset mid-packet");
        readyMode = 0;
        applyStimulus(0, 32'h55, 6, 2, 2);
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        checkResetState("midreset");
        sbQ.delete();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(0, 32'h55, 3, 1, 1);
        waitDone(20, 3);

        $display("[TB] randomized runs");
        for (int r = 0; r < 8; r++) begin
            int m, l, c;
            logic [31:0] s;
            m = $urandom_range(0, 3);
            l = $urandom_range(1, 6);
            c = $urandom_range(1, 3);
            s = $urandom;
            readyMode = 2;
            applyStimulus(m, s, l, c, c);
            waitDone(400, l * c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/axis_pattern_source.md
Name: axis_pattern_source

Overview:
- AXI4-Stream master that generates deterministic test traffic into a DMA HPx read-data slave port (axis_HPx_read_data_*). It is the producer counterpart of the DMA's stream output.
- Runs on CLK_dma and is controlled through o_CMD_regN_0 fields: start, mode, seed, packet length and packet count.
- Replaces constant tie-offs on tdata/tvalid so that DDR write-back contents can be checked against a known sequence.

Parameters:
- DATA_W, 32, stream data width in bits; must be a multiple of 8.
- LEN_W, 16, width of the packet-length and packet-count fields.

Ports:
- CLK_dma  in  1  stream clock
- peripheral_aresetn  in  1  asynchronous active-low reset
- i_start  in  1  level from CMD register bit; a rising edge starts a run
- i_abort  in  1  level; stops the run at the next packet boundary
- i_mode  in  2  pattern: 0 incrementing count, 1 constant seed, 2 LFSR, 3 walking one
- i_seed  in  DATA_W  initial pattern value
- i_pkt_len  in  LEN_W  beats per packet
- i_pkt_count  in  LEN_W  packets per run
- m_axis_tdata  out  DATA_W  stream data
- m_axis_tkeep  out  DATA_W/8  byte enables; always all ones
- m_axis_tlast  out  1  last beat of a packet
- m_axis_tvalid  out  1  data valid
- m_axis_tready  in  1  slave ready
- o_busy  out  1  high while the run is active
- o_done  out  1  sticky completion flag; cleared by the next accepted start
- o_beat_cnt  out  32  total beats accepted in the current or last run

Behaviour:
- Reset, asynchronous: state IDLE. Outputs tvalid=0, tlast=0, tdata=0, busy=0, done=0, beat_cnt=0, start edge register=0.
- tkeep is constant all ones.
- Start detection:
  - start_pulse = i_start & ~i_start_q, where i_start_q is registered.
  - start_pulse is accepted only in IDLE or DONE; it is ignored while busy.
- On accepted start:
  - Latch mode, len, count and seed.
  - Clear done and beat_cnt; set busy.
  - If len==0 or count==0: go directly to DONE (done=1, busy=0). No beat is emitted.
  - Otherwise go to SEND, with tvalid=1 on the next cycle (start-to-first-valid latency is 1 cycle).
- Handshake: a beat transfers when tvalid & tready. While tvalid=1 and tready=0, tdata and tlast hold stable and tvalid must not drop.
- SEND state:
  - beat_idx counts 0..len-1; pkt_idx counts 0..count-1.
  - tlast = (beat_idx == len-1).
  - On each transfer: beat_cnt += 1, wrapping at 2^32; the pattern advances; beat_idx increments, or returns to 0 on a tlast transfer.
  - On a tlast transfer: pkt_idx += 1.
  - If pkt_idx was count-1, or abort is pending: tvalid=0 on the next cycle, state DONE, done=1, busy=0.
  - Otherwise tvalid stays 1 with no bubble between packets.
- Abort:
  - i_abort=1 in SEND sets abort_pending.
  - The current packet always completes with tlast; abort never truncates a packet.
  - abort_pending clears on entry to DONE.
- Pattern rules (value on the first beat = P0; the pattern advances only on a transfer, and continues across packet boundaries):
  - Mode 0: P0 = seed; next = data+1 mod 2^DATA_W.
  - Mode 1: every beat = seed.
  - Mode 2: P0 = seed, or 1 if seed==0. Next = Galois LFSR, taps x^32+x^22+x^2+x+1 (shift right; XOR 0x80200003 when the LSB is 1).
  - Mode 3: P0 = 1 << seed[log2(DATA_W)-1:0]; next = rotate left by 1.
- DONE state: tvalid=0. Stays in DONE until the next accepted start; done remains 1 until then.
- Start and abort edges in the same cycle in IDLE/DONE: start is accepted and abort is ignored.
- Reset mid-packet: tvalid drops immediately. This is allowed only because reset is shared with the slave.

Optional Feature:
- Macro: AXIS_PATTERN_SOURCE_STALL_CNT_EN
- With the macro defined:
  - Adds output o_stall_cnt, 32 bits.
  - It increments every cycle with tvalid & ~tready, saturating at 0xFFFFFFFF.
  - It clears on accepted start and resets to 0.
- Without the macro: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Mode 0, seed=0x100, len=4, count=2, tready=1:
  - Required: 8 consecutive beats 0x100..0x107, tlast on beats 4 and 8.
  - done=1 and beat_cnt=8 one cycle after the last transfer.
- Mode 2, seed=0, len=3, count=1, tready toggling 1/0 each cycle:
  - Required: data 0x00000001, then 0x80200003, then the next LFSR value.
  - Data is held stable during every tready=0 cycle.
  - With the macro: stall_cnt equals the number of stalled cycles.
- Mode 3, seed=31, len=2, count=1:
  - Required: 0x80000000, then 0x00000001 with tlast.
- len=0, count=5, start:
  - Required: no tvalid; done=1 and busy=0 within 2 cycles.
- Mode 1, seed=0xA5A5A5A5, len=8, count=4; abort asserted during beat 3 of packet 1:
  - Required: packet 1 completes (8 beats, tlast), then tvalid=0.
  - beat_cnt=8, done=1.
- Second start edge while busy is ignored.
- Reset asserted mid-packet:
  - Required: all outputs return to reset values in the same cycle.
  - A fresh start after release begins again from the seed.
